mode_sequencer: RTL and testbench

//  Owns the watch's shared resources, the LCD character stream and the four debounced push-buttons,
//  and hands them to one of four mode blocks (0 watch, 1 time-set, 2 alarm, 3 stopwatch).

---
 rtl/watch_pkg.sv | 32 +++
 rtl/sync_vec.sv | 32 +++
 rtl/mode_sequencer.sv | 168 ++++++++++++++++
 tb/tb_mode_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared definitions for the watch mode sequencer.
// Contents:
//   MODE_*      committed mode encodings (watch, time-set, alarm, stopwatch)
//   seq_state_t sequencer FSM state encodings (SEQ_*)
//   decode_dip  one-hot dip switch to mode decode; anything not one-hot
//               (other than 0100 / 0010 / 0001) falls back to the watch mode
package watch_pkg;

  localparam logic [1:0] MODE_WATCH = 2'd0;
  localparam logic [1:0] MODE_SET   = 2'd1;
  localparam logic [1:0] MODE_ALARM = 2'd2;
  localparam logic [1:0] MODE_STOP  = 2'd3;

  typedef enum logic [1:0] {
    SEQ_RUN      = 2'd0,
    SEQ_PEND     = 2'd1,
    SEQ_ALARM    = 2'd2,
    SEQ_ALM_EXIT = 2'd3
  } seq_state_t;

  function automatic logic [1:0] decode_dip(input logic [3:0] sw);
    logic [1:0] m;
    case (sw)
      4'b0001: m = MODE_SET;
      4'b0010: m = MODE_ALARM;
      4'b0100: m = MODE_STOP;
      default: m = MODE_WATCH;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sync_vec.sv
// Multi-stage synchroniser for a vector of slow, asynchronous levels
// (dip switches). Bits are synchronised independently; the consumer must
// tolerate a transient mixed code while the switches move.
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset, clears every stage
//   d    raw asynchronous input
//   q    synchronised output, STAGES clocks behind d
module sync_vec #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/mode_sequencer.sv
// Mode sequencer: owns the LCD character stream and the four debounced
// buttons and hands them to one of four mode blocks (0 watch, 1 time-set,
// 2 alarm, 3 stopwatch). A dip_sw mode request is committed only at an LCD
// frame boundary so a frame never mixes two modes. An alarm hit takes the
// display at once and holds it until a button press or a timeout, after
// which the sequencer waits for the next frame boundary to hand back.
// All single-cycle inputs (clk1sec, sw_pulse, alarm_hit) are one-clk
// pulses; there is no back-pressure anywhere in this block.
// Ports:
//   clk, rst               system clock, asynchronous active-low reset
//   clk1sec                1 Hz enable pulse
//   dip_sw                 raw mode select switches
//   sw_pulse               debounced button pulses
//   alarm_hit              alarm match pulse
//   index_char             character index from lcd_driver
//   data_mode0..3          character from each mode block
//   data_char              character to lcd_driver (combinational)
//   sw_mode0..3            button pulses routed to each mode block
//   mode                   committed mode
//   alarm_active           high while the alarm screen is shown
//   buzzer                 1 Hz toggle while in the alarm state
//   dbg_state              current sequencer state
module mode_sequencer
  import watch_pkg::*;
#(
  parameter int LAST_INDEX  = 31,
  parameter int ALARM_SECS  = 60,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk1sec,
  input  logic [3:0] dip_sw,
  input  logic [3:0] sw_pulse,
  input  logic       alarm_hit,
  input  logic [4:0] index_char,
  input  logic [7:0] data_mode0,
  input  logic [7:0] data_mode1,
  input  logic [7:0] data_mode2,
  input  logic [7:0] data_mode3,
  output logic [7:0] data_char,
  output logic [3:0] sw_mode0,
  output logic [3:0] sw_mode1,
  output logic [3:0] sw_mode2,
  output logic [3:0] sw_mode3,
  output logic [1:0] mode,
  output logic       alarm_active,
  output logic       buzzer,
  output seq_state_t dbg_state
);

  seq_state_t state, next_state;
  logic [3:0] dip_sync;
  logic [1:0] req;
  logic [4:0] idx_prev;
  logic       fb;
  logic [7:0] alarm_cnt;
  logic       cnt_done;
  logic       commit;
  logic       route_en;
  logic [1:0] disp_sel;

  sync_vec #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_dip_sync (
    .clk (clk),
    .rst (rst),
    .d   (dip_sw),
    .q   (dip_sync)
  );

  assign req = decode_dip(dip_sync);

  // Frame boundary: the registered previous index was the last character
  // and the current one is back at 0. Because idx_prev follows index_char
  // every clock, fb lasts exactly one cycle however long index 0 is held.
  assign fb       = (idx_prev == 5'(LAST_INDEX)) && (index_char == 5'd0);
  assign cnt_done = (alarm_cnt >= 8'(ALARM_SECS));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SEQ_RUN;
    else      state <= next_state;
  end

  // Next-state logic. alarm_hit wins over everything else in every state.
  always_comb begin
    next_state = state;
    commit     = 1'b0;
    case (state)
      SEQ_RUN: begin
        if (alarm_hit)        next_state = SEQ_ALARM;
        else if (req != mode) next_state = SEQ_PEND;
      end
      SEQ_PEND: begin
        if (alarm_hit)        next_state = SEQ_ALARM;
        else if (req == mode) next_state = SEQ_RUN;
        else if (fb) begin
          next_state = SEQ_RUN;
          commit     = 1'b1;
        end
      end
      SEQ_ALARM: begin
        if (alarm_hit)                 next_state = SEQ_ALARM;
        else if (|sw_pulse || cnt_done) next_state = SEQ_ALM_EXIT;
      end
      SEQ_ALM_EXIT: begin
        if (alarm_hit) next_state = SEQ_ALARM;
        else if (fb) begin
          next_state = SEQ_RUN;
          commit     = 1'b1;
        end
      end
      default: next_state = SEQ_RUN;
    endcase
  end

  // Output logic. disp_sel moves with mode (which only changes at fb) or
  // with entry to / leaving of the alarm states; leaving also only at fb.
  always_comb begin
    route_en = (state == SEQ_RUN) && !alarm_hit;
    disp_sel = ((state == SEQ_ALARM) || (state == SEQ_ALM_EXIT)) ? MODE_ALARM : mode;
    case (disp_sel)
      MODE_WATCH: data_char = data_mode0;
      MODE_SET:   data_char = data_mode1;
      MODE_ALARM: data_char = data_mode2;
      default:    data_char = data_mode3;
    endcase
  end

  assign dbg_state = state;

  // Datapath registers: committed mode, frame tracking, alarm timeout,
  // routed button pulses and alarm indicators.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode         <= MODE_WATCH;
      idx_prev     <= '0;
      alarm_cnt    <= '0;
      sw_mode0     <= '0;
      sw_mode1     <= '0;
      sw_mode2     <= '0;
      sw_mode3     <= '0;
      alarm_active <= 1'b0;
      buzzer       <= 1'b0;
    end else begin
      idx_prev <= index_char;
      if (commit) mode <= req;

      // Every alarm_hit lands in SEQ_ALARM, so it always restarts the count.
      if (alarm_hit)
        alarm_cnt <= '0;
      else if ((state == SEQ_ALARM) && clk1sec && (alarm_cnt != 8'hFF))
        alarm_cnt <= alarm_cnt + 8'd1;

      sw_mode0 <= (route_en && (mode == MODE_WATCH)) ? sw_pulse : 4'd0;
      sw_mode1 <= (route_en && (mode == MODE_SET))   ? sw_pulse : 4'd0;
      sw_mode2 <= (route_en && (mode == MODE_ALARM)) ? sw_pulse : 4'd0;
      sw_mode3 <= (route_en && (mode == MODE_STOP))  ? sw_pulse : 4'd0;

      alarm_active <= (next_state == SEQ_ALARM) || (next_state == SEQ_ALM_EXIT);

      if (next_state != SEQ_ALARM)
        buzzer <= 1'b0;
      else if ((state == SEQ_ALARM) && clk1sec)
        buzzer <= ~buzzer;
    end
  end

endmodule

// File: tb/tb_mode_sequencer.sv
module tb_mode_sequencer;
  import watch_pkg::*;

  localparam logic [7:0] D0 = 8'hA0;
  localparam logic [7:0] D1 = 8'hB1;
  localparam logic [7:0] D2 = 8'hC2;
  localparam logic [7:0] D3 = 8'hD3;

  logic       clk;
  logic       rst;
  logic       clk1sec;
  logic [3:0] dip_sw;
  logic [3:0] sw_pulse;
  logic       alarm_hit;
  logic [4:0] index_char;
  logic [7:0] data_mode0, data_mode1, data_mode2, data_mode3;
  logic [7:0] data_char;
  logic [3:0] sw_mode0, sw_mode1, sw_mode2, sw_mode3;
  logic [1:0] mode;
  logic       alarm_active;
  logic       buzzer;
  seq_state_t dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  mode_sequencer #(.LAST_INDEX(31), .ALARM_SECS(3), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk1sec      (clk1sec),
    .dip_sw       (dip_sw),
    .sw_pulse     (sw_pulse),
    .alarm_hit    (alarm_hit),
    .index_char   (index_char),
    .data_mode0   (data_mode0),
    .data_mode1   (data_mode1),
    .data_mode2   (data_mode2),
    .data_mode3   (data_mode3),
    .data_char    (data_char),
    .sw_mode0     (sw_mode0),
    .sw_mode1     (sw_mode1),
    .sw_mode2     (sw_mode2),
    .sw_mode3     (sw_mode3),
    .mode         (mode),
    .alarm_active (alarm_active),
    .buzzer       (buzzer),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Routed buttons packed as {sw_mode3, sw_mode2, sw_mode1, sw_mode0}.
  task automatic check_route(input string tag);
    logic [15:0] exp;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'h0000;
    check(tag, 32'({sw_mode3, sw_mode2, sw_mode1, sw_mode0}), 32'(exp));
  endtask

  // Drivers: inputs change 1 time unit after the rising edge; outputs are
  // sampled at the same point, when registers have settled.
  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame_end();
    index_char = 5'd31;
    cycle();
    index_char = 5'd0;
    cycle();
  endtask

  task automatic pulse_alarm();
    alarm_hit = 1'b1;
    cycle();
    alarm_hit = 1'b0;
  endtask

  task automatic pulse_sec();
    clk1sec = 1'b1;
    cycle();
    clk1sec = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clk1sec = 1'b0; dip_sw = 4'b0000; sw_pulse = 4'b0000;
    alarm_hit = 1'b0; index_char = 5'd0;
    data_mode0 = D0; data_mode1 = D1; data_mode2 = D2; data_mode3 = D3;
    cycle(2);

    // 1: reset state, commit only at frame boundary
    check("rst_mode", 32'(mode), 32'(MODE_WATCH));
    check("rst_state", 32'(dbg_state), 32'(SEQ_RUN));
    check("rst_data", 32'(data_char), 32'(D0));
    check("rst_alarm", 32'({alarm_active, buzzer}), 32'(0));
    check_route("rst_route");
    rst = 1'b1;
    index_char = 5'd10;
    dip_sw = 4'b0100;
    cycle(4);
    check("t1_pend_state", 32'(dbg_state), 32'(SEQ_PEND));
    check("t1_mode_held", 32'(mode), 32'(MODE_WATCH));
    check("t1_data_held", 32'(data_char), 32'(D0));
    frame_end();
    check("t1_mode_commit", 32'(mode), 32'(MODE_STOP));
    check("t1_data_m3", 32'(data_char), 32'(D3));
    data_mode3 = 8'h5A;
    #1;
    check("t1_data_track", 32'(data_char), 32'(8'h5A));

    // 2: button routing in mode 1
    dip_sw = 4'b0001;
    cycle(4);
    frame_end();
    check("t2_mode", 32'(mode), 32'(MODE_SET));
    sw_pulse = 4'b0010;
    exp_q.push_back(16'h0020);
    cycle();
    sw_pulse = 4'b0000;
    check_route("t2_route");
    cycle();
    check_route("t2_route_width");

    // 3: request withdrawn within one frame, pulse during PEND dropped
    dip_sw = 4'b0010;
    cycle(4);
    check("t3_pend", 32'(dbg_state), 32'(SEQ_PEND));
    dip_sw = 4'b0001;
    sw_pulse = 4'b0001;
    cycle();
    sw_pulse = 4'b0000;
    check_route("t3_pend_drop");
    cycle(3);
    check("t3_back_run", 32'(dbg_state), 32'(SEQ_RUN));
    frame_end();
    check("t3_mode_kept", 32'(mode), 32'(MODE_SET));

    // 4: alarm preempts mode 3, button clears it, mode 3 back at next fb
    dip_sw = 4'b0100;
    cycle(4);
    frame_end();
    check("t4_mode3", 32'(mode), 32'(MODE_STOP));
    pulse_alarm();
    check("t4_alarm_active", 32'(alarm_active), 32'(1));
    check("t4_alarm_data", 32'(data_char), 32'(D2));
    check("t4_state", 32'(dbg_state), 32'(SEQ_ALARM));
    check("t4_buzz0", 32'(buzzer), 32'(0));
    pulse_sec();
    check("t4_buzz1", 32'(buzzer), 32'(1));
    sw_pulse = 4'b0001;
    cycle();
    sw_pulse = 4'b0000;
    check_route("t4_consumed");
    check("t4_exit_state", 32'(dbg_state), 32'(SEQ_ALM_EXIT));
    check("t4_exit_flags", 32'({alarm_active, buzzer}), 32'(2'b10));
    check("t4_exit_data", 32'(data_char), 32'(D2));
    cycle();
    check_route("t4_consumed2");
    frame_end();
    check("t4_restored", 32'(mode), 32'(MODE_STOP));
    check("t4_run", 32'(dbg_state), 32'(SEQ_RUN));
    check("t4_inactive", 32'(alarm_active), 32'(0));
    check("t4_data", 32'(data_char), 32'(8'h5A));

    // 5: timeout after the 3rd clk1sec
    pulse_alarm();
    for (int i = 0; i < 3; i++) begin
      pulse_sec();
      check("t5_buzz", 32'(buzzer), 32'((i % 2) == 0));
      check("t5_in_alarm", 32'(dbg_state), 32'(SEQ_ALARM));
      if (i < 2) cycle();
    end
    cycle();
    check("t5_timeout", 32'(dbg_state), 32'(SEQ_ALM_EXIT));
    check("t5_still_active", 32'({alarm_active, buzzer}), 32'(2'b10));
    cycle(3);
    check("t5_wait_fb", 32'(alarm_active), 32'(1));
    frame_end();
    check("t5_drop", 32'(alarm_active), 32'(0));

    // 6: alarm beats a simultaneous button; 1111 decodes to 0; async reset
    alarm_hit = 1'b1;
    sw_pulse = 4'b1000;
    cycle();
    alarm_hit = 1'b0;
    sw_pulse = 4'b0000;
    check("t6_state", 32'(dbg_state), 32'(SEQ_ALARM));
    check_route("t6_dropped");
    dip_sw = 4'b1111;
    cycle(4);
    sw_pulse = 4'b0001;
    cycle();
    sw_pulse = 4'b0000;
    frame_end();
    check("t6_decode_1111", 32'(mode), 32'(MODE_WATCH));
    check("t6_data0", 32'(data_char), 32'(D0));
    dip_sw = 4'b0001;
    cycle(4);
    frame_end();
    check("t6_mode1", 32'(mode), 32'(MODE_SET));
    pulse_alarm();
    pulse_sec();
    check("t6_pre_rst", 32'({alarm_active, buzzer}), 32'(2'b11));
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_mode", 32'(mode), 32'(MODE_WATCH));
    check("t6_rst_state", 32'(dbg_state), 32'(SEQ_RUN));
    check("t6_rst_flags", 32'({alarm_active, buzzer}), 32'(0));
    check("t6_rst_data", 32'(data_char), 32'(D0));
    check_route("t6_rst_route");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
